arb_req_frontend: RTL and testbench
===================================

# arb_req_frontend

Four-client request front end that sits directly upstream of the 4-way round-robin arbiter. Each client pushes payloads through a valid/ready handshake into a private FIFO. The block drives the arbiter's REQ vector from FIFO occupancy and consumes the arbiter's one-hot GNT to pop the granted FIFO. The popped payload is presented on a single registered output bus tagged with the client ID.

## Interface
- DW, 8: payload width per client.
- DEPTH, 2: entries per client FIFO; power of two, ≥2.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  4  per-client push request; bit i belongs to client i.
- in_data  in  4*DW  client i payload on bits [i*DW +: DW].
- in_ready  out  4  bit i = FIFO i not full.
- REQ  out  4  to arbiter; bit i = FIFO i not empty.
- GNT  in  4  from arbiter; one-hot or zero.
- out_valid  out  1  one payload issued this cycle.
- out_id  out  2  client index of the issued payload.
- out_data  out  DW  issued payload.
- err_gnt  out  1  sticky protocol-error flag.

## Operation
- Per client i: DEPTH-entry FIFO with wr_ptr and rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH.
- Per client i: occupancy counter cnt_i of log2(DEPTH)+1 bits, range 0..DEPTH.
- Push: when in_valid[i] and in_ready[i] are both high, write the payload at wr_ptr and increment wr_ptr.
- in_ready[i] = (cnt_i != DEPTH). It is combinational from registered state only and never depends on GNT, so a pop does not make room for a push in the same cycle.
- REQ[i] = (cnt_i != 0), combinational from registered count.
- Pop: when GNT[i] is high and cnt_i != 0, read the entry at rd_ptr and increment rd_ptr.
- Simultaneous push and pop on the same FIFO: both take effect and cnt_i is unchanged.
- Output register: on a pop, next cycle out_valid=1, out_id=i, out_data=popped entry. Otherwise next cycle out_valid=0, and out_id/out_data hold their last values.
- Protocol errors:
  - GNT[i] high while cnt_i == 0: no pop on that FIFO.
  - More than one GNT bit high: no pop on any FIFO.
  - Either condition sets err_gnt on the next edge. It stays set until reset.
- An empty FIFO with in_valid high does not bypass to REQ in the same cycle. REQ rises the cycle after the push.
- Reset mid-operation: all FIFO contents are discarded; pointers and counts return to 0 asynchronously.

## Timing
- Reset values: in_ready=4'b1111, REQ=4'b0000, out_valid=0, out_id=0, out_data=0, err_gnt=0.
- Push at edge k → REQ[i] high after edge k.
- The arbiter registers its state at edge k+1 → GNT[i] high in cycle k+1.
- Pop at edge k+2 → out_valid high after edge k+2, i.e. two cycles from push to issue.
- Sustained single client: one pop per cycle while its FIFO holds data.
- All clients busy: grants rotate and each client is popped once every four cycles.
- Legal operation never raises err_gnt. The arbiter only enters a grant state for a client whose REQ was high, and only that grant pops that FIFO.
- No combinational path from any input to any output except in_data → FIFO storage, which is registered.

## Test plan
- Reset check: assert rst_n=0 mid-traffic → all outputs take their reset values immediately; the first push after release issues normally.
- Single client: push 0xA1, 0xA2 on client 2 in back-to-back cycles, with the arbiter attached →
  - out_valid pulses in two consecutive cycles;
  - out_id=2 on both; out_data=0xA1 then 0xA2;
  - first issue two cycles after the first push.
- Full FIFO, DEPTH=2: client 0 pushes 3 words while GNT is held at 0 →
  - in_ready[0] drops after the second push;
  - the third word waits;
  - releasing grants delivers all 3 words in order.
- All four clients each push one word in the same cycle, starting from idle → issue order is id 0,1,2,3 in four consecutive cycles; REQ returns to 4'b0000.
- Simultaneous push and pop on client 3 with cnt=1 → cnt stays 1 and data order is preserved.
- Forced GNT=4'b0010 with FIFO 1 empty, then GNT=4'b0011 with data present →
  - no pop in either case;
  - err_gnt=1 after the first violation and remains 1.

Source files
------------

// File: rtl/arb_req_frontend.sv
// arb_req_frontend: four private client FIFOs that drive the arbiter REQ
// vector from occupancy, pop the FIFO selected by the one-hot GNT, and issue
// the popped payload on a registered output bus tagged with the client ID.
module arb_req_frontend #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      in_ready,
  output logic [3:0]      REQ,
  input  logic [3:0]      GNT,
  output logic            out_valid,
  output logic [1:0]      out_id,
  output logic [DW-1:0]   out_data,
  output logic            err_gnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [DW-1:0] mem_q    [4][DEPTH];
  logic [DW-1:0] mem_d    [4][DEPTH];
  logic [AW-1:0] wr_ptr_q [4];
  logic [AW-1:0] wr_ptr_d [4];
  logic [AW-1:0] rd_ptr_q [4];
  logic [AW-1:0] rd_ptr_d [4];
  logic [CW-1:0] cnt_q    [4];
  logic [CW-1:0] cnt_d    [4];

  logic          out_valid_q, out_valid_d;
  logic [1:0]    out_id_q, out_id_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          err_gnt_q, err_gnt_d;

  logic [3:0]    ready_s;
  logic [3:0]    req_s;
  logic [3:0]    push_s;
  logic [3:0]    pop_s;
  logic          gnt_multi_s;
  logic          gnt_empty_s;
  logic [1:0]    pop_id_s;

  // Ready/request come only from registered counts; a grant pops only when it is one-hot and lands on a non-empty FIFO.
  always_comb begin
    gnt_multi_s = ((GNT & (GNT - 4'd1)) != 4'd0);
    for (int i = 0; i < 4; i++) begin
      ready_s[i] = (cnt_q[i] != CNT_FULL);
      req_s[i]   = (cnt_q[i] != CNT_ZERO);
    end
    push_s      = in_valid & ready_s;
    pop_s       = GNT & req_s & {4{~gnt_multi_s}};
    gnt_empty_s = |(GNT & ~req_s);
  end

  // Encode the (at most one-hot) pop vector into a client index.
  always_comb begin
    case (pop_s)
      4'b0010: pop_id_s = 2'd1;
      4'b0100: pop_id_s = 2'd2;
      4'b1000: pop_id_s = 2'd3;
      default: pop_id_s = 2'd0;
    endcase
  end

  // FIFO storage, pointers and occupancy; push and pop on one FIFO leave the count unchanged.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_d[i][j] = mem_q[i][j];
      end
      if (push_s[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_data[i*DW +: DW];
        wr_ptr_d[i]           = wr_ptr_q[i] + AW'(1);
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
      if (pop_s[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
      end else begin
        rd_ptr_d[i] = rd_ptr_q[i];
      end
      case ({push_s[i], pop_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Issue register: a pop presents its entry next cycle, otherwise ID/data hold; the error flag is sticky.
  always_comb begin
    out_valid_d = |pop_s;
    if (|pop_s) begin
      out_id_d   = pop_id_s;
      out_data_d = mem_q[pop_id_s][rd_ptr_q[pop_id_s]];
    end else begin
      out_id_d   = out_id_q;
      out_data_d = out_data_q;
    end
    err_gnt_d = err_gnt_q | gnt_multi_s | gnt_empty_s;
  end

  // State register; reset discards all FIFO contents asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= {DW{1'b0}};
        end
        wr_ptr_q[i] <= {AW{1'b0}};
        rd_ptr_q[i] <= {AW{1'b0}};
        cnt_q[i]    <= CNT_ZERO;
      end
      out_valid_q <= 1'b0;
      out_id_q    <= 2'd0;
      out_data_q  <= {DW{1'b0}};
      err_gnt_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= mem_d[i][j];
        end
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
      err_gnt_q   <= err_gnt_d;
    end
  end

  assign in_ready  = ready_s;
  assign REQ       = req_s;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;
  assign err_gnt   = err_gnt_q;

endmodule

// File: tb/tb_arb_req_frontend.sv
// Bench for arb_req_frontend: directed vector table, hand-written multi-cycle
// sequences and randomized traffic checked against a queue-based model.
module tb_arb_req_frontend;

  localparam int DW    = 8;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_ready;
  logic [3:0]      REQ;
  logic [3:0]      GNT;
  logic            out_valid;
  logic [1:0]      out_id;
  logic [DW-1:0]   out_data;
  logic            err_gnt;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: one queue per client plus the expected issue register.
  logic [7:0] mq [4][$];
  logic       exp_valid;
  logic [1:0] exp_id;
  logic [7:0] exp_data;
  logic       exp_err;

  // Bench-side round-robin arbiter with a registered grant.
  logic [3:0] arb_gnt;
  int         arb_last;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  g;
    logic [3:0]  rdy;
    logic [3:0]  req;
    logic        ov;
    logic [1:0]  id;
    logic [7:0]  dat;
    logic        err;
  } vec_t;

  arb_req_frontend #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .REQ(REQ), .GNT(GNT), .out_valid(out_valid),
    .out_id(out_id), .out_data(out_data), .err_gnt(err_gnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rr_pick(input logic [3:0] elig, input int last);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (elig[c]) return 4'b0001 << c;
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    exp_valid = 1'b0;
    exp_id    = 2'd0;
    exp_data  = 8'h00;
    exp_err   = 1'b0;
    arb_gnt   = 4'b0000;
    arb_last  = 3;
  endtask

  task automatic check_model();
    logic [3:0] rdy, req;
    for (int i = 0; i < 4; i++) begin
      rdy[i] = (mq[i].size() != DEPTH);
      req[i] = (mq[i].size() != 0);
    end
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("REQ", 32'(REQ), 32'(req));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("out_id", 32'(out_id), 32'(exp_id));
    chk("out_data", 32'(out_data), 32'(exp_data));
    chk("err_gnt", 32'(err_gnt), 32'(exp_err));
  endtask

  // One clock: called at a negedge, drives inputs, advances the model, checks at the next negedge.
  task automatic tick(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g_in, input bit use_arb);
    logic [3:0] g, pop, push, elig, nxt;
    logic       onehot, perr, popped;
    g        = use_arb ? arb_gnt : g_in;
    in_valid = v;
    in_data  = d;
    GNT      = g;
    onehot   = ((g & (g - 4'd1)) == 4'd0);
    perr     = !onehot;
    for (int i = 0; i < 4; i++) begin
      if (g[i] && mq[i].size() == 0) perr = 1'b1;
      pop[i]  = onehot && g[i] && (mq[i].size() != 0);
      push[i] = v[i] && (mq[i].size() != DEPTH);
      elig[i] = (mq[i].size() - (pop[i] ? 1 : 0)) >= 1;
    end
    nxt    = rr_pick(elig, arb_last);
    popped = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) begin
        exp_data = mq[i].pop_front();
        exp_id   = 2'(i);
        popped   = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mq[i].push_back(d[i*8 +: 8]);
    end
    exp_valid = popped;
    exp_err   = exp_err | perr;
    @(posedge clk);
    arb_gnt = nxt;
    for (int i = 0; i < 4; i++) if (nxt[i]) arb_last = i;
    @(negedge clk);
    check_model();
  endtask

  // Asynchronous reset mid-cycle: outputs must reach reset values without a clock edge.
  task automatic reset_dut();
    in_valid = 4'b0000;
    in_data  = 32'h0;
    GNT      = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0000_000F);
    chk("rst_REQ", 32'(REQ), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_id", 32'(out_id), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_err_gnt", 32'(err_gnt), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_model();
  endtask

  initial begin
    vec_t tbl [10];
    logic [3:0]  rv, rg;
    logic [31:0] rd;
    int          r;

    rst_n = 1'b1;
    model_reset();
    reset_dut();

    // Full FIFO on client 0 with GNT held low, then drain; then grant protocol errors.
    tbl[0] = '{4'b0001, 32'h0000_0011, 4'b0000, 4'b1111, 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[1] = '{4'b0001, 32'h0000_0022, 4'b0000, 4'b1110, 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[2] = '{4'b0001, 32'h0000_0033, 4'b0000, 4'b1110, 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[3] = '{4'b0001, 32'h0000_0033, 4'b0001, 4'b1111, 4'b0001, 1'b1, 2'd0, 8'h11, 1'b0};
    tbl[4] = '{4'b0001, 32'h0000_0033, 4'b0001, 4'b1111, 4'b0001, 1'b1, 2'd0, 8'h22, 1'b0};
    tbl[5] = '{4'b0000, 32'h0000_0000, 4'b0001, 4'b1111, 4'b0000, 1'b1, 2'd0, 8'h33, 1'b0};
    tbl[6] = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0, 8'h33, 1'b0};
    tbl[7] = '{4'b0010, 32'h0000_4400, 4'b0010, 4'b1111, 4'b0010, 1'b0, 2'd0, 8'h33, 1'b1};
    tbl[8] = '{4'b0000, 32'h0000_0000, 4'b0011, 4'b1111, 4'b0010, 1'b0, 2'd0, 8'h33, 1'b1};
    tbl[9] = '{4'b0000, 32'h0000_0000, 4'b0010, 4'b1111, 4'b0000, 1'b1, 2'd1, 8'h44, 1'b1};
    for (int k = 0; k < 10; k++) begin
      tick(tbl[k].v, tbl[k].d, tbl[k].g, 1'b0);
      chk($sformatf("tbl%0d_in_ready", k), 32'(in_ready), 32'(tbl[k].rdy));
      chk($sformatf("tbl%0d_REQ", k), 32'(REQ), 32'(tbl[k].req));
      chk($sformatf("tbl%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].ov));
      chk($sformatf("tbl%0d_out_id", k), 32'(out_id), 32'(tbl[k].id));
      chk($sformatf("tbl%0d_out_data", k), 32'(out_data), 32'(tbl[k].dat));
      chk($sformatf("tbl%0d_err_gnt", k), 32'(err_gnt), 32'(tbl[k].err));
    end

    // Reset in the middle of arbitrated traffic.
    for (int k = 0; k < 6; k++) tick(4'b1111, $urandom, 4'b0000, 1'b1);
    reset_dut();

    // Client 2 pushes 0xA1, 0xA2 back to back with the arbiter attached.
    tick(4'b0100, 32'h00A1_0000, 4'b0000, 1'b1);
    chk("c2_t1_out_valid", 32'(out_valid), 32'h0);
    tick(4'b0100, 32'h00A2_0000, 4'b0000, 1'b1);
    chk("c2_t2_out_valid", 32'(out_valid), 32'h0);
    tick(4'b0000, 32'h0, 4'b0000, 1'b1);
    chk("c2_t3_out_valid", 32'(out_valid), 32'h1);
    chk("c2_t3_out_id", 32'(out_id), 32'h2);
    chk("c2_t3_out_data", 32'(out_data), 32'hA1);
    tick(4'b0000, 32'h0, 4'b0000, 1'b1);
    chk("c2_t4_out_valid", 32'(out_valid), 32'h1);
    chk("c2_t4_out_id", 32'(out_id), 32'h2);
    chk("c2_t4_out_data", 32'(out_data), 32'hA2);
    tick(4'b0000, 32'h0, 4'b0000, 1'b1);
    chk("c2_t5_out_valid", 32'(out_valid), 32'h0);
    chk("c2_err_gnt", 32'(err_gnt), 32'h0);

    // All four clients push one word in the same cycle from idle.
    reset_dut();
    tick(4'b1111, 32'h4433_2211, 4'b0000, 1'b1);
    tick(4'b0000, 32'h0, 4'b0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(4'b0000, 32'h0, 4'b0000, 1'b1);
      chk($sformatf("all4_%0d_out_valid", k), 32'(out_valid), 32'h1);
      chk($sformatf("all4_%0d_out_id", k), 32'(out_id), 32'(k));
      chk($sformatf("all4_%0d_out_data", k), 32'(out_data), 32'(8'h11 * (k + 1)));
    end
    chk("all4_REQ_idle", 32'(REQ), 32'h0);

    // Simultaneous push and pop on client 3 with one word stored.
    tick(4'b1000, 32'hC100_0000, 4'b0000, 1'b0);
    chk("c3_req_after_push", 32'(REQ[3]), 32'h1);
    tick(4'b1000, 32'hC200_0000, 4'b1000, 1'b0);
    chk("c3_pp_out_data", 32'(out_data), 32'hC1);
    chk("c3_pp_req", 32'(REQ[3]), 32'h1);
    chk("c3_pp_ready", 32'(in_ready[3]), 32'h1);
    tick(4'b0000, 32'h0, 4'b1000, 1'b0);
    chk("c3_last_out_valid", 32'(out_valid), 32'h1);
    chk("c3_last_out_data", 32'(out_data), 32'hC2);
    chk("c3_last_req", 32'(REQ), 32'h0);

    // Random traffic behind a legal arbiter: err_gnt must stay low.
    for (int k = 0; k < 300; k++) begin
      rv = 4'($urandom_range(0, 15));
      rd = $urandom;
      tick(rv, rd, 4'b0000, 1'b1);
    end
    chk("rand_legal_err_gnt", 32'(err_gnt), 32'h0);

    // Random raw grants, including illegal ones.
    for (int k = 0; k < 150; k++) begin
      rv = 4'($urandom_range(0, 15));
      rd = $urandom;
      r  = $urandom_range(0, 9);
      if (r < 6) rg = 4'b0001 << $urandom_range(0, 3);
      else if (r < 9) rg = 4'b0000;
      else rg = 4'($urandom_range(0, 15));
      tick(rv, rd, rg, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
